ahb_lite_master_usb: RTL

AHB-Lite initiator that turns single-beat commands from a host-side controller (test sequencer or embedded core model) into AHB-Lite NONSEQ transfers toward the USB register slave, then returns read data and an error status. It sits opposite the USB AHB-Lite slave on the same bus. It handles address-phase and data-phase wait states and the two-cycle ERROR response. Only one transfer is outstanding at a time.

---
 rtl/ahb_lite_master_usb.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master_usb.sv
// Single-outstanding AHB-Lite initiator that turns host commands into NONSEQ transfers to the USB slave.
// Optional data-phase timeout: define AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master_usb #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        hsel,
  output logic [3:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        hready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("ahb_lite_master_usb: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t      state_r, state_s;
  logic        hsel_r, hsel_s;
  logic [1:0]  htrans_r, htrans_s;
  logic [3:0]  haddr_r, haddr_s;
  logic [1:0]  hsize_r, hsize_s;
  logic        hwrite_r, hwrite_s;
  logic [31:0] hwdata_r, hwdata_s;
  logic [31:0] wdata_r, wdata_s;
  logic        resp_valid_r, resp_valid_s;
  logic        resp_error_r, resp_error_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        tmo_hit_s;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt_r;

  // Data-phase wait counter, restarted on every entry to DATA
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_s == DATA && state_r != DATA) begin
      tmo_cnt_r <= 8'd0;
    end else if (state_r == DATA && !hready && !hresp) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Fires on the wait cycle that would bring the count up to the limit
  assign tmo_hit_s = ((tmo_cnt_r + 8'd1) == TMO_LIMIT);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_s      = state_r;
    hsel_s       = 1'b0;
    htrans_s     = HTRANS_IDLE;
    haddr_s      = haddr_r;
    hsize_s      = hsize_r;
    hwrite_s     = hwrite_r;
    hwdata_s     = hwdata_r;
    wdata_s      = wdata_r;
    resp_valid_s = 1'b0;
    resp_error_s = 1'b0;
    resp_rdata_s = resp_rdata_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_s  = ADDR;
          hsel_s   = 1'b1;
          htrans_s = HTRANS_NONSEQ;
          haddr_s  = cmd_addr;
          hsize_s  = cmd_size;
          hwrite_s = cmd_write;
          wdata_s  = cmd_wdata;
        end else begin
          hwdata_s = 32'd0;
        end
      end
      ADDR: begin
        if (hresp) begin
          state_s = ERR;
        end else if (hready) begin
          state_s  = DATA;
          hwdata_s = hwrite_r ? wdata_r : 32'd0;
        end else begin
          hsel_s   = 1'b1;
          htrans_s = HTRANS_NONSEQ;
        end
      end
      DATA: begin
        if (hready) begin
          // hresp with hready is the second error cycle: finish with error at once
          state_s      = IDLE;
          resp_valid_s = 1'b1;
          resp_error_s = hresp;
          hwdata_s     = 32'd0;
          if (!hresp && !hwrite_r) begin
            resp_rdata_s = hrdata;
          end else begin
            resp_rdata_s = resp_rdata_r;
          end
        end else if (hresp) begin
          state_s  = ERR;
          hwdata_s = 32'd0;
        end else if (tmo_hit_s) begin
          state_s      = IDLE;
          resp_valid_s = 1'b1;
          resp_error_s = 1'b1;
          hwdata_s     = 32'd0;
        end else begin
          state_s = DATA;
        end
      end
      ERR: begin
        if (hready) begin
          state_s      = IDLE;
          resp_valid_s = 1'b1;
          resp_error_s = 1'b1;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered bus, response and latched-command outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hsel_r       <= 1'b0;
      htrans_r     <= HTRANS_IDLE;
      haddr_r      <= 4'd0;
      hsize_r      <= 2'd0;
      hwrite_r     <= 1'b0;
      hwdata_r     <= 32'd0;
      wdata_r      <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      hsel_r       <= hsel_s;
      htrans_r     <= htrans_s;
      haddr_r      <= haddr_s;
      hsize_r      <= hsize_s;
      hwrite_r     <= hwrite_s;
      hwdata_r     <= hwdata_s;
      wdata_r      <= wdata_s;
      resp_valid_r <= resp_valid_s;
      resp_error_r <= resp_error_s;
      resp_rdata_r <= resp_rdata_s;
    end
  end

  assign cmd_ready  = (state_r == IDLE);
  assign hsel       = hsel_r;
  assign htrans     = htrans_r;
  assign haddr      = haddr_r;
  assign hsize      = hsize_r;
  assign hwrite     = hwrite_r;
  assign hwdata     = hwdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_error = resp_error_r;
  assign resp_rdata = resp_rdata_r;

endmodule
